// File: rtl/noc_pkg.sv
// Shared types and helpers for the synchronous mesh router: port encoding,
// dimension-ordered route function and round-robin pick.
package noc_pkg;

  localparam int NPORTS = 5;

  typedef enum logic [2:0] {
    PE = 3'd0,
    N  = 3'd1,
    E  = 3'd2,
    S  = 3'd3,
    W  = 3'd4
  } port_e;

  // X first, then Y; a flit already at its destination goes to the local PE.
  function automatic port_e xy_route(input int dx, input int dy, input int myx, input int myy);
    port_e p;
    if (dx > myx) begin
      p = E;
    end else if (dx < myx) begin
      p = W;
    end else if (dy > myy) begin
      p = N;
    end else if (dy < myy) begin
      p = S;
    end else begin
      p = PE;
    end
    return p;
  endfunction

  function automatic logic [2:0] rr_pick(input logic [NPORTS-1:0] req, input logic [2:0] ptr);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = (int'(ptr) + k) % NPORTS;
      if (!found && req[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/noc_router_sync_if.sv
// Five-port flit handshake bundle between a router and its neighbours.
interface noc_router_sync_if #(parameter int WIDTH = 15);
  import noc_pkg::*;

  logic [NPORTS-1:0]            in_valid;
  logic [NPORTS-1:0][WIDTH-1:0] in_data;
  logic [NPORTS-1:0]            in_ready;
  logic [NPORTS-1:0]            out_valid;
  logic [NPORTS-1:0][WIDTH-1:0] out_data;
  logic [NPORTS-1:0]            out_ready;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/noc_fifo_sync.sv
// Per-input flit FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module noc_fifo_sync #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign head      = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/noc_router_sync.sv
// Single-flit 5-port mesh router: input FIFOs, XY route decode, per-output
// round-robin arbitration into registered output slots, dropped-flit counter.
module noc_router_sync
  import noc_pkg::*;
#(
  parameter int                WIDTH   = 15,
  parameter int                DEPTH   = 4,
  parameter int                ROW     = 4,
  parameter int                COL     = 4,
  parameter int                MY_X    = 0,
  parameter int                MY_Y    = 0,
  parameter int                X_LSB   = 4,
  parameter int                Y_LSB   = 7,
  parameter logic [NPORTS-1:0] PORT_EN = 5'b11111
) (
  input  logic               clk,
  input  logic               rst_n,
  noc_router_sync_if.slave   bus,
  output logic               drop_pulse,
  output logic [7:0]         drop_cnt
);
  localparam int XW = (COL > 1) ? $clog2(COL) : 1;
  localparam int YW = (ROW > 1) ? $clog2(ROW) : 1;

  logic [NPORTS-1:0][WIDTH-1:0]  head_s;
  logic [NPORTS-1:0]             full_s, empty_s, push_s, pop_s, drop_s, in_ready_s;
  int                            dx_s [NPORTS];
  int                            dy_s [NPORTS];
  port_e                         dest_s [NPORTS];
  logic [NPORTS-1:0][NPORTS-1:0] req_s;
  logic [NPORTS-1:0]             grant_s;
  logic [2:0]                    grantee_s [NPORTS];
  logic [2:0]                    n_drop_s;
  logic [8:0]                    cnt_sum_s;

  logic [NPORTS-1:0]             out_valid_r;
  logic [NPORTS-1:0][WIDTH-1:0]  out_data_r;
  logic [2:0]                    rr_ptr_r [NPORTS];
  logic                          drop_pulse_r;
  logic [7:0]                    drop_cnt_r;

  // Readiness looks only at registered occupancy, never at a same-cycle pop.
  assign in_ready_s    = PORT_EN & ~full_s;
  assign push_s        = bus.in_valid & in_ready_s;
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign drop_pulse    = drop_pulse_r;
  assign drop_cnt      = drop_cnt_r;

  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    noc_fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s[p]),
      .din   (bus.in_data[p]),
      .pop   (pop_s[p]),
      .full  (full_s[p]),
      .empty (empty_s[p]),
      .head  (head_s[p])
    );
  end

  // Route decode: each non-empty head either requests one output or is dropped.
  always_comb begin
    req_s  = '0;
    drop_s = '0;
    for (int p = 0; p < NPORTS; p++) begin
      dx_s[p]   = int'(head_s[p][X_LSB +: XW]);
      dy_s[p]   = int'(head_s[p][Y_LSB +: YW]);
      dest_s[p] = xy_route(dx_s[p], dy_s[p], MY_X, MY_Y);
      if (empty_s[p]) begin
        drop_s[p] = 1'b0;
      end else if (dx_s[p] >= COL || dy_s[p] >= ROW || !PORT_EN[dest_s[p]]) begin
        drop_s[p] = 1'b1;
      end else begin
        req_s[dest_s[p]][p] = 1'b1;
      end
    end
  end

  // Per-output arbitration; drops and grants together form the FIFO pops.
  always_comb begin
    grant_s = '0;
    pop_s   = drop_s;
    for (int o = 0; o < NPORTS; o++) begin
      grantee_s[o] = rr_pick(req_s[o], rr_ptr_r[o]);
      if ((!out_valid_r[o] || bus.out_ready[o]) && (|req_s[o])) begin
        grant_s[o]            = 1'b1;
        pop_s[grantee_s[o]]   = 1'b1;
      end else begin
        grant_s[o] = 1'b0;
      end
    end
  end

  // Number of flits dropped this cycle and the unsaturated next count.
  always_comb begin
    n_drop_s = 3'd0;
    for (int p = 0; p < NPORTS; p++) begin
      n_drop_s = n_drop_s + {2'b00, drop_s[p]};
    end
    cnt_sum_s = {1'b0, drop_cnt_r} + {6'b000000, n_drop_s};
  end

  // Output slots and round-robin pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= '0;
      out_data_r  <= '0;
      for (int o = 0; o < NPORTS; o++) begin
        rr_ptr_r[o] <= 3'd0;
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (grant_s[o]) begin
          out_valid_r[o] <= 1'b1;
          out_data_r[o]  <= head_s[grantee_s[o]];
          rr_ptr_r[o]    <= (grantee_s[o] == 3'd4) ? 3'd0 : grantee_s[o] + 3'd1;
        end else if (bus.out_ready[o]) begin
          out_valid_r[o] <= 1'b0;
        end else begin
          out_valid_r[o] <= out_valid_r[o];
        end
      end
    end
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_r <= 1'b0;
      drop_cnt_r   <= 8'd0;
    end else begin
      drop_pulse_r <= |drop_s;
      drop_cnt_r   <= (cnt_sum_s > 9'd255) ? 8'd255 : cnt_sum_s[7:0];
    end
  end

endmodule

// File: tb/tb_noc_router_sync.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-level router model.
module tb_noc_router_sync;
  localparam int WIDTH = 15;
  localparam int DEPTH = 4;
  localparam int P_PE = 0, P_N = 1, P_E = 2, P_S = 3, P_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drop_pulse_a, drop_pulse_b;
  logic [7:0] drop_cnt_a, drop_cnt_b;
  int         n_tests = 0;
  int         n_fail = 0;

  noc_router_sync_if #(.WIDTH(WIDTH)) bus_a ();
  noc_router_sync_if #(.WIDTH(WIDTH)) bus_b ();

  noc_router_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ROW(4), .COL(4), .MY_X(1), .MY_Y(1),
                    .X_LSB(4), .Y_LSB(7), .PORT_EN(5'b11111)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .drop_pulse(drop_pulse_a), .drop_cnt(drop_cnt_a));

  noc_router_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ROW(3), .COL(3), .MY_X(1), .MY_Y(1),
                    .X_LSB(4), .Y_LSB(7), .PORT_EN(5'b11101)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .drop_pulse(drop_pulse_b), .drop_cnt(drop_cnt_b));

  always #5 clk = ~clk;

  // Reference model state for dut_a: per-input queues, output slots, RR pointers.
  logic [14:0]       mbuf [5][DEPTH];
  int                mcnt [5];
  logic [4:0]        mov;
  logic [4:0][14:0]  mod;
  int                mrr [5];

  function automatic logic [14:0] mk_flit(input int dx, input int dy, input int tag);
    logic [14:0] f;
    f      = 15'(tag);
    f[5:4] = 2'(dx);
    f[8:7] = 2'(dy);
    return f;
  endfunction

  function automatic int m_route(input logic [14:0] f);
    int dx, dy;
    dx = int'(f[5:4]);
    dy = int'(f[8:7]);
    if (dx > 1) return P_E;
    if (dx < 1) return P_W;
    if (dy > 1) return P_N;
    if (dy < 1) return P_S;
    return P_PE;
  endfunction

  task automatic model_step(input logic [4:0] iv, input logic [4:0][14:0] id, input logic [4:0] ordy);
    bit acc [5];
    bit popd [5];
    int dst [5];
    bit got;
    int p;
    for (int i = 0; i < 5; i++) begin
      acc[i]  = iv[i] && (mcnt[i] < DEPTH);
      popd[i] = 1'b0;
      dst[i]  = (mcnt[i] > 0) ? m_route(mbuf[i][0]) : -1;
    end
    for (int o = 0; o < 5; o++) begin
      got = 1'b0;
      if (!mov[o] || ordy[o]) begin
        for (int k = 0; k < 5; k++) begin
          p = (mrr[o] + k) % 5;
          if (!got && dst[p] == o) begin
            got = 1'b1;
            mod[o] = mbuf[p][0];
            popd[p] = 1'b1;
            mrr[o] = (p + 1) % 5;
          end
        end
      end
      if (got) mov[o] = 1'b1;
      else if (ordy[o]) mov[o] = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      if (popd[i]) begin
        for (int j = 0; j < DEPTH - 1; j++) mbuf[i][j] = mbuf[i][j+1];
        mcnt[i]--;
      end
      if (acc[i]) begin
        mbuf[i][mcnt[i]] = id[i];
        mcnt[i]++;
      end
    end
  endtask

  task automatic clear_inputs();
    bus_a.in_valid = '0; bus_a.in_data = '0; bus_a.out_ready = '1;
    bus_b.in_valid = '0; bus_b.in_data = '0; bus_b.out_ready = '1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #3;
    n_tests++; if (bus_a.out_valid !== 5'b00000) begin n_fail++; $display("FAIL reset_hold_out_valid got=%b exp=00000", bus_a.out_valid); end
    do_reset();
    n_tests++; if (bus_a.out_valid !== 5'b00000) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=00000", bus_a.out_valid); end
    n_tests++; if (bus_a.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", bus_a.out_data); end
    n_tests++; if (drop_cnt_a !== 8'd0 || drop_pulse_a !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%0d/%b exp=0/0", drop_cnt_a, drop_pulse_a); end
    n_tests++; if (bus_a.in_ready !== 5'b11111) begin n_fail++; $display("FAIL reset_in_ready_a got=%b exp=11111", bus_a.in_ready); end
    n_tests++; if (bus_b.in_ready !== 5'b11101) begin n_fail++; $display("FAIL reset_in_ready_b got=%b exp=11101", bus_b.in_ready); end
  endtask

  task automatic test_single_flit();
    logic [14:0] f;
    do_reset();
    f = mk_flit(3, 1, 15'h7A05);
    bus_a.in_valid[P_PE] = 1'b1;
    bus_a.in_data[P_PE]  = f;
    @(posedge clk); #1;
    bus_a.in_valid = '0;
    n_tests++; if (bus_a.out_valid !== 5'b00000) begin n_fail++; $display("FAIL single_edge1 got=%b exp=00000", bus_a.out_valid); end
    @(posedge clk); #1;
    n_tests++; if (bus_a.out_valid !== 5'b00100) begin n_fail++; $display("FAIL single_edge2_valid got=%b exp=00100", bus_a.out_valid); end
    n_tests++; if (bus_a.out_data[P_E] !== f) begin n_fail++; $display("FAIL single_edge2_data got=%h exp=%h", bus_a.out_data[P_E], f); end
    @(posedge clk); #1;
    n_tests++; if (bus_a.out_valid !== 5'b00000) begin n_fail++; $display("FAIL single_drain got=%b exp=00000", bus_a.out_valid); end
  endtask

  task automatic test_rr_order();
    logic [14:0] fl [5];
    int ord [4];
    ord = '{P_PE, P_N, P_S, P_W};
    do_reset();
    for (int p = 0; p < 5; p++) begin
      fl[p] = mk_flit(3, 1, (p + 1) * 512 + p);
      bus_a.in_data[p] = fl[p];
    end
    bus_a.in_valid = 5'b11011;
    @(posedge clk); #1;
    bus_a.in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (bus_a.out_valid !== 5'b00100 || bus_a.out_data[P_E] !== fl[ord[i]]) begin
        n_fail++;
        $display("FAIL rr_order slot=%0d got=%b/%h exp=00100/%h", i, bus_a.out_valid, bus_a.out_data[P_E], fl[ord[i]]);
      end
    end
    @(posedge clk); #1;
    n_tests++; if (bus_a.out_valid !== 5'b00000) begin n_fail++; $display("FAIL rr_drain got=%b exp=00000", bus_a.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [14:0] fw [7];
    int  n_acc;
    logic rdy;
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 7; i++) fw[i] = mk_flit(2, 1, (i + 1) * 512 + i);
    bus_a.out_ready = 5'b11011;
    for (int i = 0; i < 7; i++) begin
      bus_a.in_valid[P_W] = 1'b1;
      bus_a.in_data[P_W]  = fw[n_acc];
      rdy = bus_a.in_ready[P_W];
      @(posedge clk); #1;
      if (rdy) n_acc++;
    end
    bus_a.in_valid = '0;
    n_tests++; if (n_acc !== 5) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=5", n_acc); end
    n_tests++; if (bus_a.in_ready[P_W] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", bus_a.in_ready[P_W]); end
    bus_a.out_ready = 5'b11111;
    for (int j = 0; j < 5; j++) begin
      n_tests++;
      if (bus_a.out_valid[P_E] !== 1'b1 || bus_a.out_data[P_E] !== fw[j]) begin
        n_fail++;
        $display("FAIL bp_drain idx=%0d got=%b/%h exp=1/%h", j, bus_a.out_valid[P_E], bus_a.out_data[P_E], fw[j]);
      end
      @(posedge clk); #1;
    end
    n_tests++; if (bus_a.out_valid[P_E] !== 1'b0 || bus_a.in_ready[P_W] !== 1'b1) begin n_fail++; $display("FAIL bp_empty got=%b/%b exp=0/1", bus_a.out_valid[P_E], bus_a.in_ready[P_W]); end
  endtask

  task automatic test_disabled_drop();
    do_reset();
    bus_b.in_valid[P_N] = 1'b1;
    bus_b.in_data[P_N]  = mk_flit(1, 1, 3);
    bus_b.in_valid[P_PE] = 1'b1;
    bus_b.in_data[P_PE]  = mk_flit(1, 2, 5);
    @(posedge clk); #1;
    bus_b.in_valid[P_PE] = 1'b0;
    n_tests++; if (drop_pulse_b !== 1'b0 || drop_cnt_b !== 8'd0) begin n_fail++; $display("FAIL dis_edge1 got=%b/%0d exp=0/0", drop_pulse_b, drop_cnt_b); end
    @(posedge clk); #1;
    n_tests++; if (drop_pulse_b !== 1'b1 || drop_cnt_b !== 8'd1) begin n_fail++; $display("FAIL dis_drop got=%b/%0d exp=1/1", drop_pulse_b, drop_cnt_b); end
    @(posedge clk); #1;
    n_tests++; if (drop_pulse_b !== 1'b0 || drop_cnt_b !== 8'd1) begin n_fail++; $display("FAIL dis_pulse_end got=%b/%0d exp=0/1", drop_pulse_b, drop_cnt_b); end
    bus_b.in_valid[P_PE] = 1'b1; bus_b.in_data[P_PE] = mk_flit(3, 0, 6);
    bus_b.in_valid[P_E]  = 1'b1; bus_b.in_data[P_E]  = mk_flit(3, 1, 7);
    @(posedge clk); #1;
    bus_b.in_valid[P_PE] = 1'b0; bus_b.in_valid[P_E] = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (drop_pulse_b !== 1'b1 || drop_cnt_b !== 8'd3) begin n_fail++; $display("FAIL dis_double got=%b/%0d exp=1/3", drop_pulse_b, drop_cnt_b); end
    @(posedge clk); #1;
    n_tests++; if (bus_b.out_valid !== 5'b00000) begin n_fail++; $display("FAIL dis_no_output got=%b exp=00000", bus_b.out_valid); end
    n_tests++; if (bus_b.in_ready[P_N] !== 1'b0) begin n_fail++; $display("FAIL dis_in_ready_n got=%b exp=0", bus_b.in_ready[P_N]); end
    bus_b.in_valid = '0;
  endtask

  task automatic test_drop_saturate();
    int   n_acc, cyc;
    logic rdy;
    int   targets [2];
    int   expc [2];
    targets = '{100, 300};
    expc    = '{100, 255};
    do_reset();
    n_acc = 0;
    for (int s = 0; s < 2; s++) begin
      cyc = 0;
      while (n_acc < targets[s] && cyc < 400) begin
        bus_b.in_valid[P_PE] = 1'b1;
        bus_b.in_data[P_PE]  = (n_acc % 2 == 0) ? mk_flit(3, 1, n_acc) : mk_flit(0, 3, n_acc);
        rdy = bus_b.in_ready[P_PE];
        @(posedge clk); #1;
        if (rdy) n_acc++;
        cyc++;
      end
      bus_b.in_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (n_acc !== targets[s]) begin n_fail++; $display("FAIL sat_stream_timeout got=%0d exp=%0d", n_acc, targets[s]); end
      n_tests++; if (drop_cnt_b !== 8'(expc[s]) || drop_pulse_b !== 1'b0) begin n_fail++; $display("FAIL sat_count got=%0d/%b exp=%0d/0", drop_cnt_b, drop_pulse_b, expc[s]); end
    end
  endtask

  task automatic test_reset_midop();
    bit bad;
    do_reset();
    bus_a.out_ready = '0;
    for (int i = 0; i < 3; i++) begin
      bus_a.in_valid = 5'b01011;
      bus_a.in_data[P_PE] = mk_flit(3, 1, 512 + i);
      bus_a.in_data[P_N]  = mk_flit(3, 1, 1024 + i);
      bus_a.in_data[P_S]  = mk_flit(3, 1, 2048 + i);
      @(posedge clk); #1;
    end
    bus_a.in_valid = '0;
    @(posedge clk); #1;
    n_tests++; if (bus_a.out_valid[P_E] !== 1'b1) begin n_fail++; $display("FAIL midrst_loaded got=%b exp=1", bus_a.out_valid[P_E]); end
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if (bus_a.out_valid !== 5'b00000 || bus_a.out_data !== '0) begin n_fail++; $display("FAIL midrst_async got=%b exp=00000", bus_a.out_valid); end
    #3 rst_n = 1'b1;
    bus_a.out_ready = '1;
    @(posedge clk); #1;
    n_tests++; if (bus_a.in_ready !== 5'b11111) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=11111", bus_a.in_ready); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_a.out_valid !== 5'b00000) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL midrst_stale got=stale_flit exp=none"); end
  endtask

  task automatic test_random();
    logic [4:0]       iv, ordy, exp_rdy;
    logic [4:0][14:0] id;
    do_reset();
    for (int p = 0; p < 5; p++) begin mcnt[p] = 0; mrr[p] = 0; end
    mov = '0;
    mod = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 500) begin
        iv = 5'($urandom_range(0, 31));
        for (int p = 0; p < 5; p++) begin
          id[p]    = 15'($urandom);
          ordy[p]  = ($urandom_range(0, 3) != 0);
        end
      end else begin
        iv = '0; id = '0; ordy = '1;
      end
      bus_a.in_valid = iv; bus_a.in_data = id; bus_a.out_ready = ordy;
      model_step(iv, id, ordy);
      @(posedge clk); #1;
      for (int p = 0; p < 5; p++) exp_rdy[p] = (mcnt[p] < DEPTH);
      n_tests++; if (bus_a.out_valid !== mov) begin n_fail++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, bus_a.out_valid, mov); end
      n_tests++; if (bus_a.out_data !== mod) begin n_fail++; $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", cyc, bus_a.out_data, mod); end
      n_tests++; if (bus_a.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, bus_a.in_ready, exp_rdy); end
    end
    n_tests++; if (drop_cnt_a !== 8'd0) begin n_fail++; $display("FAIL rand_no_drops got=%0d exp=0", drop_cnt_a); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_flit();
    test_rr_order();
    test_backpressure();
    test_disabled_drop();
    test_drop_saturate();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
